// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the RV32I multicycle controller.
// Holds the 16-state encoding, RV32I base opcodes, immediate-select codes
// and the funct3 access-width codes used by the byte-enable generator.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAddr = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExecR   = 4'd6,
    StExecI   = 4'd7,
    StAluWb   = 4'd8,
    StBr      = 4'd9,
    StJal     = 4'd10,
    StJalr    = 4'd11,
    StLinkWb  = 4'd12,
    StUpper   = 4'd13,
    StUpperWb = 4'd14,
    StTrap    = 4'd15
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  localparam logic [2:0] ImmNone  = 3'b000;
  localparam logic [2:0] ImmU     = 3'b001;
  localparam logic [2:0] ImmJ     = 3'b010;
  localparam logic [2:0] ImmI     = 3'b011;
  localparam logic [2:0] ImmB     = 3'b100;
  localparam logic [2:0] ImmS     = 3'b101;
  localparam logic [2:0] ImmShamt = 3'b110;

  localparam logic [1:0] WidthByte = 2'b00;
  localparam logic [1:0] WidthHalf = 2'b01;
  localparam logic [1:0] WidthWord = 2'b10;

endpackage

// File: rtl/mc_ctrl_fsm_be_gen.sv
// Byte-enable generator for the unified memory port.
// Ports:
//   width_i      funct3[1:0] access width (byte/half/word)
//   addr_lo_i    effective-address byte offset
//   be_o         byte enables for the access
//   misaligned_o access cannot be performed (bad alignment or reserved width)
module mc_ctrl_fsm_be_gen
  import mc_ctrl_pkg::*;
(
  input  logic [1:0] width_i,
  input  logic [1:0] addr_lo_i,
  output logic [3:0] be_o,
  output logic       misaligned_o
);

  always_comb begin
    be_o         = 4'b0000;
    misaligned_o = 1'b0;
    unique case (width_i)
      WidthByte: be_o = 4'b0001 << addr_lo_i;
      WidthHalf: begin
        be_o         = 4'b0011 << addr_lo_i;
        misaligned_o = addr_lo_i[0];
      end
      WidthWord: begin
        be_o         = 4'b1111;
        misaligned_o = |addr_lo_i;
      end
      // Width code 11 is reserved in RV32I; treat as a misaligned trap.
      default: misaligned_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle control unit for RV32I: fetch, decode, execute, memory, writeback.
// Adds a variable-latency memory handshake, byte enables, trap handling and a
// retired-instruction counter.
// Ports:
//   CLK, RSTn         clock; synchronous active-low reset (forces outputs to 0)
//   opcode_i/funct3_i instruction fields from the IR
//   addr_lo_i         ALU result[1:0], effective-address byte offset
//   mem_ready_i       memory completes the current request this cycle
//   mem_req_o/mem_we_o/be_o         memory port controls
//   ir_write_o, alu_src1_o, alu_src2_o, alu_op_o, imm_sel_o   datapath controls
//   reg_write_o, mem_to_reg_o, pc_write_o, branch_o, jump_o, jal_or_jalr_o
//   illegal_o         sticky trap flag
//   state_o           current state (debug)
//   retired_cnt_o     retired-instruction count, wraps modulo 2^CNT_W
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter bit          MEM_WAIT = 1'b1,
  parameter bit          TRAP_EN  = 1'b1
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [6:0]       opcode_i,
  input  logic [2:0]       funct3_i,
  input  logic [1:0]       addr_lo_i,
  input  logic             mem_ready_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [3:0]       be_o,
  output logic             ir_write_o,
  output logic             alu_src1_o,
  output logic             alu_src2_o,
  output logic [6:0]       alu_op_o,
  output logic [2:0]       imm_sel_o,
  output logic             reg_write_o,
  output logic             mem_to_reg_o,
  output logic             pc_write_o,
  output logic             branch_o,
  output logic             jump_o,
  output logic             jal_or_jalr_o,
  output logic             illegal_o,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] retired_cnt_o
);

  state_e             state_q, state_d;
  logic               illegal_q;
  logic [CNT_W-1:0]   retired_q;
  logic [3:0]         be_acc;
  logic               misaligned;
  logic               ready;
  logic               is_load;

  mc_ctrl_fsm_be_gen u_be_gen (
    .width_i      (funct3_i[1:0]),
    .addr_lo_i    (addr_lo_i),
    .be_o         (be_acc),
    .misaligned_o (misaligned)
  );

  // With MEM_WAIT=0 every memory access completes in one cycle.
  assign ready   = MEM_WAIT ? mem_ready_i : 1'b1;
  assign is_load = (opcode_i == OpLoad);

  always_comb begin
    state_d       = state_q;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    be_o          = 4'b0000;
    ir_write_o    = 1'b0;
    alu_src1_o    = 1'b0;
    alu_src2_o    = 1'b0;
    alu_op_o      = opcode_i;
    imm_sel_o     = ImmNone;
    reg_write_o   = 1'b0;
    mem_to_reg_o  = 1'b0;
    pc_write_o    = 1'b0;
    branch_o      = 1'b0;
    jump_o        = 1'b0;
    jal_or_jalr_o = 1'b0;

    unique case (state_q)
      StFetch: begin
        alu_op_o   = 7'd0;
        mem_req_o  = 1'b1;
        be_o       = 4'b1111;
        ir_write_o = ready;
        if (ready) state_d = StDecode;
      end
      StDecode: begin
        alu_op_o = 7'd0;
        unique case (opcode_i)
          OpLoad, OpStore: state_d = StMemAddr;
          OpReg:           state_d = StExecR;
          OpImm:           state_d = StExecI;
          OpBranch:        state_d = StBr;
          OpJal:           state_d = StJal;
          OpJalr:          state_d = StJalr;
          OpLui, OpAuipc:  state_d = StUpper;
          default: begin
            if (TRAP_EN) begin
              state_d = StTrap;
            end else begin
              // Unknown opcode retires as a NOP.
              pc_write_o = 1'b1;
              state_d    = StFetch;
            end
          end
        endcase
      end
      StMemAddr: begin
        alu_src2_o = 1'b1;
        imm_sel_o  = is_load ? ImmI : ImmS;
        if (misaligned) begin
          if (TRAP_EN) begin
            state_d = StTrap;
          end else begin
            pc_write_o = 1'b1;
            state_d    = StFetch;
          end
        end else begin
          state_d = is_load ? StMemRd : StMemWr;
        end
      end
      StMemRd: begin
        mem_req_o = 1'b1;
        be_o      = be_acc;
        if (ready) state_d = StMemWb;
      end
      StMemWb: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
        pc_write_o   = 1'b1;
        state_d      = StFetch;
      end
      StMemWr: begin
        mem_req_o  = 1'b1;
        mem_we_o   = 1'b1;
        be_o       = be_acc;
        pc_write_o = ready;
        if (ready) state_d = StFetch;
      end
      StExecR: state_d = StAluWb;
      StExecI: begin
        alu_src2_o = 1'b1;
        imm_sel_o  = (funct3_i[1:0] == 2'b01) ? ImmShamt : ImmI;
        state_d    = StAluWb;
      end
      StAluWb, StUpperWb: begin
        reg_write_o = 1'b1;
        pc_write_o  = 1'b1;
        state_d     = StFetch;
      end
      StBr: begin
        branch_o   = 1'b1;
        imm_sel_o  = ImmB;
        pc_write_o = 1'b1;
        state_d    = StFetch;
      end
      StJal: begin
        alu_src1_o = 1'b1;
        alu_src2_o = 1'b1;
        jump_o     = 1'b1;
        imm_sel_o  = ImmJ;
        state_d    = StLinkWb;
      end
      StJalr: begin
        alu_src2_o    = 1'b1;
        jump_o        = 1'b1;
        jal_or_jalr_o = 1'b1;
        imm_sel_o     = ImmI;
        state_d       = StLinkWb;
      end
      StLinkWb: begin
        jump_o        = 1'b1;
        jal_or_jalr_o = (opcode_i == OpJalr);
        reg_write_o   = 1'b1;
        pc_write_o    = 1'b1;
        state_d       = StFetch;
      end
      StUpper: begin
        alu_src1_o = 1'b1;
        alu_src2_o = 1'b1;
        imm_sel_o  = ImmU;
        state_d    = StUpperWb;
      end
      StTrap: state_d = StTrap;
      default: state_d = StFetch;
    endcase

    // Reset masks every output immediately, even mid-access.
    if (!RSTn) begin
      mem_req_o     = 1'b0;
      mem_we_o      = 1'b0;
      be_o          = 4'b0000;
      ir_write_o    = 1'b0;
      alu_src1_o    = 1'b0;
      alu_src2_o    = 1'b0;
      alu_op_o      = 7'd0;
      imm_sel_o     = ImmNone;
      reg_write_o   = 1'b0;
      mem_to_reg_o  = 1'b0;
      pc_write_o    = 1'b0;
      branch_o      = 1'b0;
      jump_o        = 1'b0;
      jal_or_jalr_o = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_q | (state_d == StTrap);
      if (pc_write_o) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign illegal_o     = RSTn & illegal_q;
  assign state_o       = RSTn ? state_q : 4'd0;
  assign retired_cnt_o = RSTn ? retired_q : '0;

endmodule
